// File: rtl/rtc_arbiter_pkg.sv
// Shared constants and types for the RTC access arbiter: register offsets,
// FSM state encoding and the CTRL read-back layout.
package rtc_arbiter_pkg;

  localparam int unsigned BUS_64 = 64;

  localparam logic [4:0] RTC_ADDR_TIME  = 5'h00;
  localparam logic [4:0] RTC_ADDR_ALARM = 5'h08;
  localparam logic [4:0] RTC_ADDR_CTRL  = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic [BUS_64-1:0] ctrl_word(input logic alarm_en, input logic pending);
    return {{(BUS_64-2){1'b0}}, pending, alarm_en};
  endfunction

endpackage

// File: rtl/rtc_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: lone requests win outright, ties go to the
// requester that was not granted last. The pointer moves on every accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic prio_q;  // 1: m1 wins the next tie

  // NOTE: every path assigns grant_o, so no latch is inferred.
  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (accept_i) begin
      prio_q <= grant_o[0];
    end
  end

endmodule

// File: rtl/rtc_arbiter.sv
// Arbitrates two MMIO requesters onto the RTC read port, one snapshot access
// at a time, and adds a 64-bit alarm with a sticky pending interrupt.
module rtc_arbiter
  import rtc_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [4:0]        m0_req_addr,
  input  logic              m0_req_wen,
  input  logic [BUS_64-1:0] m0_req_wdata,
  output logic              m0_resp_valid,
  input  logic              m0_resp_ready,
  output logic [BUS_64-1:0] m0_resp_rdata,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [4:0]        m1_req_addr,
  input  logic              m1_req_wen,
  input  logic [BUS_64-1:0] m1_req_wdata,
  output logic              m1_resp_valid,
  input  logic              m1_resp_ready,
  output logic [BUS_64-1:0] m1_resp_rdata,
  output logic              rtc_ren,
  input  logic [BUS_64-1:0] rtc_rdata,
  output logic              irq
);

  state_e            state_q;
  logic              owner_q;
  logic [4:0]        addr_q;
  logic              wen_q;
  logic [BUS_64-1:0] wdata_q;
  logic [BUS_64-1:0] rdata_q;
  logic [BUS_64-1:0] rdata_d;
  logic [BUS_64-1:0] alarm_q;
  logic              alarm_en_q;
  logic              pending_q;
  logic              match_q;
  logic              match_prev_q;

  logic [1:0] grant;
  logic       in_idle;
  logic       accept;
  logic       owner_resp_ready;
  logic       alarm_rise;
  logic       ctrl_w1c;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({m1_req_valid, m0_req_valid}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign in_idle      = (state_q == ST_IDLE);
  assign accept       = in_idle && (grant != 2'b00);
  // Ready is forced low while reset is held, even though state already reads IDLE.
  assign m0_req_ready = in_idle && grant[0] && !rst;
  assign m1_req_ready = in_idle && grant[1] && !rst;

  assign m0_resp_valid = (state_q == ST_RESP) && !owner_q;
  assign m1_resp_valid = (state_q == ST_RESP) &&  owner_q;
  assign m0_resp_rdata = m0_resp_valid ? rdata_q : '0;
  assign m1_resp_rdata = m1_resp_valid ? rdata_q : '0;
  assign owner_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;

  assign rtc_ren    = (state_q == ST_ACCESS) || alarm_en_q;
  assign alarm_rise = match_q && !match_prev_q;
  assign irq        = pending_q;
  assign ctrl_w1c   = (state_q == ST_ACCESS) && wen_q && (addr_q == RTC_ADDR_CTRL) && wdata_q[1];

  always_comb begin
    rdata_d = '0;
    if (!wen_q) begin
      unique case (addr_q)
        RTC_ADDR_TIME:  rdata_d = rtc_rdata;
        RTC_ADDR_ALARM: rdata_d = alarm_q;
        RTC_ADDR_CTRL:  rdata_d = ctrl_word(alarm_en_q, pending_q);
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      alarm_q      <= '0;
      alarm_en_q   <= 1'b0;
      pending_q    <= 1'b0;
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
    end else begin
      match_q      <= alarm_en_q && (rtc_rdata == alarm_q);
      match_prev_q <= match_q;

      // A new alarm edge beats a same-cycle W1C so no event is lost.
      if (alarm_rise) begin
        pending_q <= 1'b1;
      end else if (ctrl_w1c) begin
        pending_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= grant[1];
            addr_q  <= grant[1] ? m1_req_addr  : m0_req_addr;
            wen_q   <= grant[1] ? m1_req_wen   : m0_req_wen;
            wdata_q <= grant[1] ? m1_req_wdata : m0_req_wdata;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata_q <= rdata_d;
          if (wen_q && (addr_q == RTC_ADDR_ALARM)) begin
            alarm_q <= wdata_q;
          end
          if (wen_q && (addr_q == RTC_ADDR_CTRL)) begin
            alarm_en_q <= wdata_q[0];
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_resp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
